// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the SRAM memory controller.
// SRAM_OUT_REG_EN selects a registered SRAM read path (read latency 2 instead of 1).
package mem_ctrl_pkg;

  localparam int NUM_CH_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 14;
  localparam int MAX_BE_W   = 64;

`ifdef SRAM_OUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // Active-low bit mask; reads leave every bit disabled.
  function automatic logic [MAX_BE_W*8-1:0] be_to_bweb(input logic [MAX_BE_W-1:0] be,
                                                       input logic we);
    logic [MAX_BE_W*8-1:0] m;
    m = '1;
    if (we)
      for (int k = 0; k < MAX_BE_W; k++) m[k*8 +: 8] = {8{~be[k]}};
    return m;
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; ptr moves past the winner on every grant.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter  int N  = NUM_CH_DEF,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            c_i;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c_i   = 0;
    for (int k = 0; k < N; k++) begin
      c_i = (int'(ptr) + k) % N;
      if (!found && req[c_i]) begin
        found      = 1'b1;
        gnt[c_i]   = 1'b1;
        idx        = IW'(c_i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (adv && found)
      ptr <= (int'(idx) == N-1) ? '0 : IW'(int'(idx) + 1);
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Shares one single-port SRAM between NUM_CH requestors with tagged read responses.
// SRAM_OUT_REG_EN: register sram_do before rsp_rdata (latency 2).
module sram_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  localparam int BE_W   = DATA_W/8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH*BE_W-1:0]     req_be,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       sram_ceb,
  output logic                       sram_web,
  output logic [DATA_W-1:0]          sram_bweb,
  output logic [ADDR_W-1:0]          sram_a,
  output logic [DATA_W-1:0]          sram_di,
  input  logic [DATA_W-1:0]          sram_do
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]     req_m, gnt, rd_tag;
  logic [IW-1:0]         idx;
  logic                  hs, sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [MAX_BE_W*8-1:0] bweb_full;

  // Grants are masked in reset so no handshake can occur.
  assign req_m = req_valid & {NUM_CH{~rst}};

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_m),
    .adv (~rst),
    .gnt (gnt),
    .idx (idx)
  );

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign sel_we    = req_we[idx];
  assign sel_be    = req_be[int'(idx)*BE_W +: BE_W];
  assign sel_addr  = req_addr[int'(idx)*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[int'(idx)*DATA_W +: DATA_W];
  assign bweb_full = be_to_bweb(MAX_BE_W'(sel_be), sel_we);

  always_comb begin
    sram_ceb  = 1'b1;
    sram_web  = 1'b1;
    sram_bweb = '1;
    sram_a    = '0;
    sram_di   = '0;
    if (hs) begin
      sram_ceb  = 1'b0;
      sram_web  = ~sel_we;
      sram_bweb = bweb_full[DATA_W-1:0];
      sram_a    = sel_addr;
      sram_di   = sel_wdata;
    end
  end

  // One-hot tag of the accepted read travels alongside the SRAM latency.
  assign rd_tag = gnt & {NUM_CH{~sel_we}};

  logic [RD_LAT:1][NUM_CH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else begin
      for (int s = RD_LAT; s > 1; s--) vld_pipe[s] <= vld_pipe[s-1];
      vld_pipe[1] <= rd_tag;
    end
  end

  assign rsp_valid = vld_pipe[RD_LAT] & {NUM_CH{~rst}};

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst)
      rdata_q <= '0;
    else
      rdata_q <= (|vld_pipe[1]) ? sram_do : '0;
  end

  assign rsp_rdata = rst ? '0 : rdata_q;
`else
  assign rsp_rdata = (|vld_pipe[1] && !rst) ? sram_do : '0;
`endif

endmodule

// File: doc/sram_mem_ctrl.md
# sram_mem_ctrl

Parametrised multi-channel controller that shares one single-port SRAM macro between several requestors, such as the CPU instruction-fetch and data ports. It replaces direct per-port SRAM_wrapper hookups in top with round-robin arbitration, a valid/ready request handshake, byte-enable writes and tagged read responses. It sits between the CPU ports and one SRAM_wrapper instance, driving that wrapper's active-low CEB/WEB/BWEB interface.

## Interface
- NUM_CH, 2, number of requesting channels (1..8)
- DATA_W, 32, data width; multiple of 8
- ADDR_W, 14, word address width
- BE_W, DATA_W/8, byte-enable width (derived, not overridable)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_CH  per-channel request valid
- req_ready  out  NUM_CH  per-channel grant; one-hot or zero
- req_we  in  NUM_CH  1 = write, 0 = read
- req_be  in  NUM_CH*BE_W  byte enables, channel i at [i*BE_W +: BE_W]
- req_addr  in  NUM_CH*ADDR_W  word addresses, packed the same way
- req_wdata  in  NUM_CH*DATA_W  write data, packed the same way
- rsp_valid  out  NUM_CH  read data valid for channel i; one-hot or zero
- rsp_rdata  out  DATA_W  read data, shared by all channels
- sram_ceb  out  1  chip enable, active low
- sram_web  out  1  write enable, active low
- sram_bweb  out  DATA_W  bit write enable, active low
- sram_a  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data; valid the cycle after a read access

## Operation
- Arbiter: combinational round-robin over req_valid, starting at pointer ptr.
  - The first valid channel at or after ptr (modulo NUM_CH) gets req_ready=1.
  - Handshake is req_valid & req_ready. A request is accepted in the cycle the handshake occurs.
  - After a grant to channel g, ptr <= (g+1) mod NUM_CH. With no grant, ptr holds.
- req_ready never asserts without req_valid. Requestors hold all request fields stable until the handshake.
- SRAM drive is combinational from the granted channel in the handshake cycle:
  - sram_ceb=0, sram_a=addr, sram_di=wdata, sram_web=~we.
  - Write: sram_bweb[8k+j] = ~be[k]. Read: sram_bweb = all ones.
- Idle cycle: sram_ceb=1, sram_web=1, sram_bweb all ones, sram_a=0, sram_di=0.
- A write with be=0 still consumes the slot and produces no change in memory.
- Writes produce no response.
- Reads push the one-hot channel tag into the response pipeline. rsp_valid[tag]=1 with rsp_rdata=sram_do after the read latency.
- Responses cannot be back-pressured; requestors must accept them.
- Back-to-back reads from any channels are sustained: 1 accept per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data, because the SRAM write completes at the edge ending the write cycle.

## Timing
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, ptr=0.
  - sram_ceb=1, sram_web=1, sram_bweb all ones, sram_a=0, sram_di=0.
- While rst=1 no handshake occurs; all grants are masked.
- Read latency, from handshake cycle N: rsp_valid in cycle N+1 (N+2 with SRAM_OUT_REG_EN).
- Reset mid-operation: any read accepted before an edge where rst=1 has its response dropped. The pipeline is cleared and rsp_valid stays 0.
- A read and its response may coincide with a new grant in the same cycle. They are independent.

## Configuration
- SRAM_OUT_REG_EN:
  - Defined: sram_do is registered before rsp_rdata. Read latency is 2 and the tag pipeline is 2 deep.
  - Undefined: rsp_rdata = sram_do combinationally, gated to 0 when no response is due. Read latency is 1.

## Structure
- Package mem_ctrl_pkg holds:
  - default parameter constants: NUM_CH_DEF, DATA_W_DEF, ADDR_W_DEF
  - function be_to_bweb(be, we), returning the active-low bit mask
  - RD_LAT constant selected by SRAM_OUT_REG_EN
- Sub-module rr_arbiter (parameter N) contains:
  - inputs: req, plus an advance strobe
  - outputs: one-hot gnt and index idx
  - state: the ptr register
- Top-level sram_mem_ctrl holds the request mux, SRAM drive, tag shift register and output data register.

## Test plan
- Reset: hold rst 3 cycles with req_valid=2'b11. Required: req_ready=0, sram_ceb=1, rsp_valid=0 throughout; first grant goes to ch0 in the cycle after rst falls.
- Round-robin: keep req_valid=2'b11 with reads for 4 cycles. Required: grants ch0, ch1, ch0, ch1; rsp_valid pattern matches after RD_LAT.
- Byte write: ch1 writes 0xAABBCCDD to addr 0x10 with be=4'b1111, then 0x11223344 with be=4'b0101, then reads addr 0x10. Required: rdata 0xAA22CC44; sram_bweb=0xFF00FF00 on the second write.
- Back-to-back read-after-write: ch0 writes 0xDEADBEEF to 0x3, then ch0 reads 0x3 in the next cycle. Required: rsp_rdata=0xDEADBEEF on rsp_valid[0].
- Reset mid-read: ch0 read accepted in cycle N, rst=1 at edge N+1. Required: no rsp_valid pulse, ptr=0.
- Zero-BE write: write 0x0 to a preloaded 0x12345678 with be=0, then read back. Required: 0x12345678 and sram_bweb all ones.
